// File: rtl/turn_signal_ctrl.sv
// Turn-signal / hazard / emergency-stop flasher controller.
// Debounced buttons drive a mode machine with a restartable blink generator.
module turn_signal_ctrl #(
    parameter int DEBOUNCE_CYC   = 500_000,
    parameter int BLINK_HALF_CYC = 25_000_000,
    parameter int ESS_HALF_CYC   = 6_250_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_hazard,
    input  logic       ess_active,
    input  logic       engine_on,
    output logic       turn_signal_on,
    output logic       led_left,
    output logic       led_right,
    output logic [2:0] mode
);
    localparam int DW   = $clog2(DEBOUNCE_CYC + 1);
    localparam int HMAX = (BLINK_HALF_CYC > ESS_HALF_CYC) ?
                          BLINK_HALF_CYC : ESS_HALF_CYC;
    localparam int BW   = $clog2(HMAX + 1);

    localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYC - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF_CYC - 1);
    localparam logic [BW-1:0] ESS_LAST   = BW'(ESS_HALF_CYC - 1);

    typedef enum logic [2:0] {
        OFF    = 3'd0,
        LEFT   = 3'd1,
        RIGHT  = 3'd2,
        HAZARD = 3'd3,
        ESS    = 3'd4
    } mode_t;

    mode_t          state, state_nx;
    mode_t          saved, saved_nx;
    logic [2:0]     raw, sync1, sync2, db, db_q, press;
    logic [DW-1:0]  dcnt [3];
    logic           ev_h, ev_l, ev_r;
    logic           phase, phase_nx;
    logic [BW-1:0]  bcnt, bcnt_nx, last;

    // bit 0 = left, bit 1 = right, bit 2 = hazard
    assign raw = {btn_hazard, btn_right, btn_left};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
            db    <= '0;
            db_q  <= '0;
            for (int i = 0; i < 3; i++) dcnt[i] <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            db_q  <= db;
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] == db[i]) begin
                    dcnt[i] <= '0;
                end else if (dcnt[i] == DB_LAST) begin
                    db[i]   <= sync2[i];
                    dcnt[i] <= '0;
                end else begin
                    dcnt[i] <= dcnt[i] + DW'(1);
                end
            end
        end
    end

    assign press = db & ~db_q;
    assign ev_h  = press[2];
    assign ev_l  = press[0] & ~press[2];
    assign ev_r  = press[1] & ~press[0] & ~press[2];

    always_comb begin
        state_nx = state;
        saved_nx = saved;
        if (state != ESS && ess_active) begin
            state_nx = ESS;
            saved_nx = state;
        end else if (state == ESS) begin
            if (!ess_active) begin
                state_nx = saved;
                if ((saved == LEFT || saved == RIGHT) && !engine_on)
                    state_nx = OFF;
            end
        end else if ((state == LEFT || state == RIGHT) && !engine_on) begin
            state_nx = OFF;
        end else begin
            case (state)
                OFF: begin
                    if (ev_h)                   state_nx = HAZARD;
                    else if (ev_l && engine_on) state_nx = LEFT;
                    else if (ev_r && engine_on) state_nx = RIGHT;
                end
                LEFT: begin
                    if (ev_h)      state_nx = HAZARD;
                    else if (ev_l) state_nx = OFF;
                    else if (ev_r) state_nx = RIGHT;
                end
                RIGHT: begin
                    if (ev_h)      state_nx = HAZARD;
                    else if (ev_l) state_nx = LEFT;
                    else if (ev_r) state_nx = OFF;
                end
                HAZARD: begin
                    if (ev_h) state_nx = OFF;
                end
                default: state_nx = OFF;
            endcase
        end
    end

    // Any change into a lit mode restarts with the lamp on, so it clicks at once.
    always_comb begin
        last     = (state == ESS) ? ESS_LAST : BLINK_LAST;
        phase_nx = phase;
        bcnt_nx  = bcnt + BW'(1);
        if (state_nx == OFF) begin
            phase_nx = 1'b0;
            bcnt_nx  = '0;
        end else if (state_nx != state) begin
            phase_nx = 1'b1;
            bcnt_nx  = '0;
        end else if (bcnt == last) begin
            phase_nx = ~phase;
            bcnt_nx  = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= OFF;
            saved     <= OFF;
            phase     <= 1'b0;
            bcnt      <= '0;
            led_left  <= 1'b0;
            led_right <= 1'b0;
        end else begin
            state     <= state_nx;
            saved     <= saved_nx;
            phase     <= phase_nx;
            bcnt      <= bcnt_nx;
            led_left  <= phase_nx &
                         (state_nx inside {LEFT, HAZARD, ESS});
            led_right <= phase_nx &
                         (state_nx inside {RIGHT, HAZARD, ESS});
        end
    end

    assign turn_signal_on = phase;
    assign mode           = state;

endmodule

// File: tb/tb_turn_signal_ctrl.sv
// Bench for turn_signal_ctrl: directed plan steps, then random traffic,
// all checked every cycle against a window/time based reference model.
module tb_turn_signal_ctrl;
    localparam int D  = 4;
    localparam int BH = 10;
    localparam int EH = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] btn;
    logic       ess_active;
    logic       engine_on;
    logic       turn_signal_on;
    logic       led_left;
    logic       led_right;
    logic [2:0] mode;

    int checks = 0;
    int passes = 0;

    turn_signal_ctrl #(
        .DEBOUNCE_CYC  (D),
        .BLINK_HALF_CYC(BH),
        .ESS_HALF_CYC  (EH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .btn_left      (btn[0]),
        .btn_right     (btn[1]),
        .btn_hazard    (btn[2]),
        .ess_active    (ess_active),
        .engine_on     (engine_on),
        .turn_signal_on(turn_signal_on),
        .led_left      (led_left),
        .led_right     (led_right),
        .mode          (mode)
    );

    always #5 clk = ~clk;

    // Reference model: raw-sample history per button, mode as int,
    // blink phase derived from time elapsed since the last restart.
    bit q [3][$];
    bit m_db [3];
    bit m_rose [3];
    int m_mode, m_saved, t, t0;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0d expected %0d at %0t",
                    tag, obs, exp, $time);
    endtask

    task automatic model_reset();
        m_mode  = 0;
        m_saved = 0;
        t       = 0;
        t0      = 0;
        for (int i = 0; i < 3; i++) begin
            q[i].delete();
            for (int k = 0; k < D + 2; k++) q[i].push_back(1'b0);
            m_db[i]   = 1'b0;
            m_rose[i] = 1'b0;
        end
    endtask

    task automatic model_edge();
        bit ev_h, ev_l, ev_r, all_diff;
        int nm;
        t++;
        ev_h = m_rose[2];
        ev_l = m_rose[0] && !ev_h;
        ev_r = m_rose[1] && !ev_h && !m_rose[0];
        nm = m_mode;
        if (m_mode != 4 && ess_active) begin
            nm = 4;
            m_saved = m_mode;
        end else if (m_mode == 4) begin
            if (!ess_active) begin
                nm = m_saved;
                if ((nm == 1 || nm == 2) && !engine_on) nm = 0;
            end
        end else if ((m_mode == 1 || m_mode == 2) && !engine_on) begin
            nm = 0;
        end else begin
            case (m_mode)
                0: if (ev_h) nm = 3;
                   else if (ev_l) nm = engine_on ? 1 : 0;
                   else if (ev_r) nm = engine_on ? 2 : 0;
                1: if (ev_h) nm = 3; else if (ev_l) nm = 0;
                   else if (ev_r) nm = 2;
                2: if (ev_h) nm = 3; else if (ev_l) nm = 1;
                   else if (ev_r) nm = 0;
                3: if (ev_h) nm = 0;
                default: nm = 0;
            endcase
        end
        if (nm != m_mode && nm != 0) t0 = t;
        m_mode = nm;
        // db flips once the last D synchronised samples all disagree with it
        for (int i = 0; i < 3; i++) begin
            all_diff = 1'b1;
            for (int j = 1; j <= D; j++)
                if (q[i][q[i].size() - 1 - j] == m_db[i]) all_diff = 1'b0;
            m_rose[i] = 1'b0;
            if (all_diff) begin
                m_db[i]   = !m_db[i];
                m_rose[i] = m_db[i];
            end
            q[i].push_back(btn[i]);
            void'(q[i].pop_front());
        end
    endtask

    task automatic step();
        int half, ph, el, er;
        @(posedge clk);
        model_edge();
        #1;
        half = (m_mode == 4) ? EH : BH;
        ph = (m_mode == 0) ? 0 : ((((t - t0) / half) % 2) == 0 ? 1 : 0);
        el = (ph == 1 && (m_mode == 1 || m_mode == 3 || m_mode == 4)) ? 1 : 0;
        er = (ph == 1 && (m_mode == 2 || m_mode == 3 || m_mode == 4)) ? 1 : 0;
        chk("mode", int'(mode), m_mode);
        chk("turn_signal_on", int'(turn_signal_on), ph);
        chk("led_left", int'(led_left), el);
        chk("led_right", int'(led_right), er);
    endtask

    task automatic press(input int b, input int exp);
        btn[b] = 1'b1;
        repeat (7) step();
        chk("press_mode", int'(mode), exp);
        chk("press_phase", int'(turn_signal_on), (exp != 0) ? 1 : 0);
        btn[b] = 1'b0;
        repeat (8) step();
    endtask

    int hold [3];

    initial begin
        rst        = 1'b1;
        btn        = '0;
        ess_active = 1'b0;
        engine_on  = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mode", int'(mode), 0);
        chk("rst_tso", int'(turn_signal_on), 0);
        chk("rst_leds", int'({led_left, led_right}), 0);
        rst = 1'b0;

        engine_on = 1'b1;
        step();
        for (int r = 0; r < 3; r++) begin
            btn[0] = 1'b1;
            repeat (3) step();
            btn[0] = 1'b0;
            step();
        end
        repeat (10) step();
        chk("bounce_mode", int'(mode), 0);

        btn[0] = 1'b1;
        repeat (6) step();
        chk("left_edge6", int'(mode), 0);
        step();
        chk("left_edge7", int'(mode), 1);
        chk("left_led", int'(led_left), 1);
        step();
        btn[0] = 1'b0;
        repeat (40) step();

        press(1, 2);
        repeat (12) step();
        press(1, 0);
        repeat (3) step();

        press(2, 3);
        ess_active = 1'b1;
        step();
        chk("ess_mode", int'(mode), 4);
        chk("ess_leds", int'({led_left, led_right}), 3);
        btn[0] = 1'b1;
        repeat (7) step();
        btn[0] = 1'b0;
        repeat (8) step();
        chk("ess_ignore", int'(mode), 4);
        ess_active = 1'b0;
        step();
        chk("ess_exit", int'(mode), 3);
        chk("ess_exit_ph", int'(turn_signal_on), 1);
        repeat (25) step();

        press(2, 0);
        press(1, 2);
        engine_on = 1'b0;
        step();
        chk("eng_off_right", int'(mode), 0);
        engine_on = 1'b1;
        step();
        press(2, 3);
        engine_on = 1'b0;
        repeat (5) step();
        chk("eng_off_haz", int'(mode), 3);
        press(2, 0);
        engine_on = 1'b1;
        step();

        btn = 3'b101;
        repeat (7) step();
        chk("simul_haz", int'(mode), 3);
        btn = '0;
        repeat (13) step();
        rst = 1'b1;
        #1;
        chk("arst_mode", int'(mode), 0);
        chk("arst_tso", int'(turn_signal_on), 0);
        chk("arst_leds", int'({led_left, led_right}), 0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 3; i++) hold[i] = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 3; i++) begin
                if (hold[i] == 0) begin
                    btn[i]  = 1'($urandom_range(0, 1));
                    hold[i] = int'($urandom_range(1, 12));
                end else begin
                    hold[i]--;
                end
            end
            if ($urandom_range(0, 59) == 0) ess_active = ~ess_active;
            if ($urandom_range(0, 79) == 0) engine_on = ~engine_on;
            step();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
